// File: rtl/mar_arb_pkg.sv
// Shared types and constants for the MAR access arbiter.
package mar_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic OWN_F = 1'b0;
    localparam logic OWN_D = 1'b1;

    localparam int TMO_W = 8;

endpackage

// File: rtl/mar_access_arbiter_if.sv
// Requester, MAR and memory-side signals of the MAR access arbiter.
interface mar_access_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  f_req;
    logic [DATA_WIDTH-1:0] f_addr;
    logic                  f_ack;
    logic                  d_req;
    logic                  d_we;
    logic [DATA_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic                  d_ack;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  err;
    logic                  mar_load;
    logic [DATA_WIDTH-1:0] mar_addr;
    logic                  mem_rd;
    logic                  mem_wr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_ready;

    modport slave (
        input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        output f_ack, d_ack, rdata, err, mar_load, mar_addr, mem_rd, mem_wr, mem_wdata
    );

    modport master (
        output f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        input  f_ack, d_ack, rdata, err, mar_load, mar_addr, mem_rd, mem_wr, mem_wdata
    );

endinterface

// File: rtl/mar_arb_pick.sv
// Combinational winner selection between fetch and data requests.
// ARB_RR_EN selects round-robin on the last owner; otherwise D has fixed priority.
module mar_arb_pick
    import mar_arb_pkg::*;
(
    input  logic f_req,
    input  logic d_req,
`ifdef ARB_RR_EN
    input  logic last_owner,
`endif
    output logic valid,
    output logic owner
);

    always_comb begin
        valid = f_req | d_req;
        owner = OWN_F;
        if (f_req && d_req) begin
`ifdef ARB_RR_EN
            owner = (last_owner == OWN_F) ? OWN_D : OWN_F;
`else
            owner = OWN_D;
`endif
        end else if (d_req) begin
            owner = OWN_D;
        end
    end

endmodule

// File: rtl/mar_access_arbiter.sv
// Arbitrates the MAR and memory port between instruction fetch (F) and load/store (D).
// Define ARB_RR_EN for round-robin arbitration; default is fixed priority D over F.
module mar_access_arbiter
    import mar_arb_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    mar_access_arbiter_if.slave  bus
);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    state_t                  state;
    logic                    grant;
    logic                    we;
    logic [TMO_W-1:0]        cnt;
    logic                    f_ack;
    logic                    d_ack;
    logic                    err;
    logic                    mar_load;
    logic                    mem_rd;
    logic                    mem_wr;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [DATA_WIDTH-1:0]   mar_addr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic                    pick_valid;
    logic                    pick_owner;

    // grant doubles as the last-owner history in round-robin builds
    mar_arb_pick u_pick (
        .f_req      (bus.f_req),
        .d_req      (bus.d_req),
`ifdef ARB_RR_EN
        .last_owner (grant),
`endif
        .valid      (pick_valid),
        .owner      (pick_owner)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            grant     <= OWN_F;
            we        <= 1'b0;
            cnt       <= '0;
            f_ack     <= 1'b0;
            d_ack     <= 1'b0;
            err       <= 1'b0;
            mar_load  <= 1'b0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            rdata     <= '0;
            mar_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mar_load <= 1'b0;
            f_ack    <= 1'b0;
            d_ack    <= 1'b0;
            err      <= 1'b0;
            rdata    <= '0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant    <= pick_owner;
                        mar_load <= 1'b1;
                        state    <= LOAD;
                        if (pick_owner == OWN_D) begin
                            mar_addr  <= bus.d_addr;
                            we        <= bus.d_we;
                            mem_wdata <= bus.d_we ? bus.d_wdata : '0;
                        end else begin
                            mar_addr  <= bus.f_addr;
                            we        <= 1'b0;
                            mem_wdata <= '0;
                        end
                    end
                end
                LOAD: begin
                    cnt    <= '0;
                    mem_rd <= !we;
                    mem_wr <= we;
                    state  <= ACCESS;
                end
                ACCESS: begin
                    // ready in the last allowed cycle still counts as success
                    if (bus.mem_ready || cnt == TMO_LAST) begin
                        mem_rd <= 1'b0;
                        mem_wr <= 1'b0;
                        f_ack  <= (grant == OWN_F);
                        d_ack  <= (grant == OWN_D);
                        err    <= !bus.mem_ready;
                        rdata  <= (bus.mem_ready && !we) ? bus.mem_rdata : '0;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.f_ack     = f_ack;
    assign bus.d_ack     = d_ack;
    assign bus.rdata     = rdata;
    assign bus.err       = err;
    assign bus.mar_load  = mar_load;
    assign bus.mar_addr  = mar_addr;
    assign bus.mem_rd    = mem_rd;
    assign bus.mem_wr    = mem_wr;
    assign bus.mem_wdata = mem_wdata;

endmodule

// File: tb/tb_mar_access_arbiter.sv
// Self-checking bench for mar_access_arbiter with an ack scoreboard and a latency-programmable memory.
module tb_mar_access_arbiter;

    localparam int DW  = 32;
    localparam int TMO = 15;

    typedef struct packed {
        logic          is_d;
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mar_access_arbiter_if #(.DATA_WIDTH(DW)) bus ();

    mar_access_arbiter #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    // memory model: ready comes in the ready_lat-th strobe cycle, never when ready_lat is 0
    int ready_lat = 0;
    int acc_cnt = 0;
    logic [DW-1:0] mem_val = '0;

    always @(posedge clk or negedge reset) begin
        if (!reset) acc_cnt <= 0;
        else if (bus.mem_rd | bus.mem_wr) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
    end

    assign bus.mem_ready = (bus.mem_rd | bus.mem_wr) && (ready_lat != 0) && (acc_cnt + 1 == ready_lat);
    assign bus.mem_rdata = mem_val;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t required earlier", $time);
        $fatal(1);
    end

    task automatic wait_ack(input int limit, output logic seen, output logic fa, output logic da,
                            output logic [DW-1:0] rd, output logic er, output int n_acc,
                            output logic rd_seen, output logic wr_seen);
        seen = 0; fa = 0; da = 0; rd = '0; er = 0; n_acc = 0; rd_seen = 0; wr_seen = 0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            if (bus.mem_rd | bus.mem_wr) n_acc++;
            if (bus.mem_rd) rd_seen = 1;
            if (bus.mem_wr) wr_seen = 1;
            if (bus.f_ack | bus.d_ack) begin
                seen = 1; fa = bus.f_ack; da = bus.d_ack; rd = bus.rdata; er = bus.err;
            end
        end
    endtask

    task automatic test_reset();
        logic [4*DW+6:0] outs;
        int acks;
        bus.f_req = 0; bus.f_addr = '0; bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
        @(negedge clk);
        outs = {bus.f_ack, bus.d_ack, bus.rdata, bus.err, bus.mar_load, bus.mar_addr,
                bus.mem_rd, bus.mem_wr, bus.mem_wdata};
        checks++;
        if (outs !== '0) begin errors++; $display("FAIL reset_outputs got %h want 0", outs); end
        reset = 1;
        @(negedge clk);
        ready_lat = 0;
        bus.f_addr = 32'h0000_0055; bus.f_req = 1;
        for (int i = 0; i < 10 && !bus.mem_rd; i++) @(negedge clk);
        checks++;
        if (bus.mem_rd !== 1'b1) begin errors++; $display("FAIL reset_reach_access mem_rd got %b want 1", bus.mem_rd); end
        #2 reset = 0;
        #1;
        outs = {bus.f_ack, bus.d_ack, bus.rdata, bus.err, bus.mar_load, bus.mar_addr,
                bus.mem_rd, bus.mem_wr, bus.mem_wdata};
        checks++;
        if (outs !== '0) begin errors++; $display("FAIL reset_async_outputs got %h want 0", outs); end
        bus.f_req = 0;
        @(negedge clk);
        reset = 1;
        acks = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.f_ack | bus.d_ack | bus.mem_rd | bus.mar_load) acks++;
        end
        checks++;
        if (acks != 0) begin errors++; $display("FAIL reset_no_ack activity cycles got %0d want 0", acks); end
    endtask

    task automatic test_fetch();
        exp_t e;
        mem_val = 32'hDEAD_BEEF; ready_lat = 1;
        bus.f_addr = 32'h0000_ABCD; bus.f_req = 1;
        sb.push_back('{is_d: 1'b0, rdata: 32'hDEAD_BEEF, err: 1'b0});
        @(negedge clk);
        checks++;
        if ({bus.mar_load, bus.mar_addr} !== {1'b1, 32'h0000_ABCD}) begin
            errors++; $display("FAIL fetch_load got %b/%h want 1/0000abcd", bus.mar_load, bus.mar_addr);
        end
        @(negedge clk);
        checks++;
        if ({bus.mar_load, bus.mem_rd, bus.mem_wr} !== 3'b010) begin
            errors++; $display("FAIL fetch_access load/rd/wr got %b%b%b want 010", bus.mar_load, bus.mem_rd, bus.mem_wr);
        end
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if ({bus.f_ack, bus.d_ack, bus.rdata, bus.err} !== {~e.is_d, e.is_d, e.rdata, e.err}) begin
            errors++; $display("FAIL fetch_ack got f%b d%b %h e%b want f1 d0 %h e0",
                               bus.f_ack, bus.d_ack, bus.rdata, bus.err, e.rdata);
        end
        bus.f_req = 0;
        @(negedge clk);
        checks++;
        if ({bus.f_ack, bus.rdata} !== '0) begin
            errors++; $display("FAIL fetch_ack_pulse got %b/%h want 0/0", bus.f_ack, bus.rdata);
        end
    endtask

    task automatic test_write();
        exp_t e; logic seen, fa, da, er, rs, ws; logic [DW-1:0] rd; int n;
        ready_lat = 3; mem_val = 32'h1111_2222;
        bus.d_we = 1; bus.d_addr = 32'h1234_5678; bus.d_wdata = 32'hCAFE_F00D; bus.d_req = 1;
        sb.push_back('{is_d: 1'b1, rdata: '0, err: 1'b0});
        wait_ack(30, seen, fa, da, rd, er, n, rs, ws);
        bus.d_req = 0; bus.d_we = 0;
        checks++;
        if (!seen) begin
            errors++; $display("FAIL write_ack no ack within 30 cycles, want ack");
        end else begin
            e = sb.pop_front();
            checks++;
            if ({fa, da, rd, er} !== {~e.is_d, e.is_d, e.rdata, e.err}) begin
                errors++; $display("FAIL write_ack got f%b d%b %h e%b want f0 d1 %h e0", fa, da, rd, er, e.rdata);
            end
        end
        checks++;
        if ({rs, ws, n} !== {1'b0, 1'b1, 32'd3}) begin
            errors++; $display("FAIL write_strobes rd_seen %b wr_seen %b cycles %0d want 0 1 3", rs, ws, n);
        end
        checks++;
        if ({bus.mar_addr, bus.mem_wdata} !== {32'h1234_5678, 32'hCAFE_F00D}) begin
            errors++; $display("FAIL write_addr_data got %h/%h want 12345678/cafef00d", bus.mar_addr, bus.mem_wdata);
        end
        @(negedge clk);
    endtask

    task automatic test_contention();
        exp_t e; logic seen, fa, da, er, rs, ws; logic [DW-1:0] rd; int n; int grants;
        ready_lat = 2; mem_val = 32'h0BAD_F00D;
        bus.f_addr = 32'h0000_00F0; bus.d_addr = 32'h0000_00D0; bus.d_we = 0;
`ifdef ARB_RR_EN
        grants = 4;
        sb.push_back('{is_d: 1'b1, rdata: 32'h0BAD_F00D, err: 1'b0});
        sb.push_back('{is_d: 1'b0, rdata: 32'h0BAD_F00D, err: 1'b0});
        sb.push_back('{is_d: 1'b1, rdata: 32'h0BAD_F00D, err: 1'b0});
        sb.push_back('{is_d: 1'b0, rdata: 32'h0BAD_F00D, err: 1'b0});
`else
        grants = 2;
        sb.push_back('{is_d: 1'b1, rdata: 32'h0BAD_F00D, err: 1'b0});
        sb.push_back('{is_d: 1'b0, rdata: 32'h0BAD_F00D, err: 1'b0});
`endif
        bus.f_req = 1; bus.d_req = 1;
        for (int k = 0; k < grants; k++) begin
            wait_ack(30, seen, fa, da, rd, er, n, rs, ws);
            checks++;
            if (!seen) begin
                errors++; $display("FAIL contention_ack grant %0d no ack within 30 cycles", k);
            end else begin
                e = sb.pop_front();
                checks++;
                if ({fa, da, rd, er, bus.mar_addr} !==
                    {~e.is_d, e.is_d, e.rdata, e.err, (e.is_d ? 32'h0000_00D0 : 32'h0000_00F0)}) begin
                    errors++; $display("FAIL contention_order grant %0d got f%b d%b %h addr %h want d%b %h",
                                       k, fa, da, rd, bus.mar_addr, e.is_d, e.rdata);
                end
`ifndef ARB_RR_EN
                if (da) bus.d_req = 0;
                if (fa) bus.f_req = 0;
`endif
            end
        end
        bus.f_req = 0; bus.d_req = 0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        exp_t e; logic seen, fa, da, er, rs, ws; logic [DW-1:0] rd; int n;
        ready_lat = 1; mem_val = 32'h7777_0001; bus.f_addr = 32'h0000_0100;
        sb.push_back('{is_d: 1'b0, rdata: 32'h7777_0001, err: 1'b0});
        sb.push_back('{is_d: 1'b0, rdata: 32'h7777_0001, err: 1'b0});
        bus.f_req = 1;
        wait_ack(20, seen, fa, da, rd, er, n, rs, ws);
        checks++;
        if (!seen) begin
            errors++; $display("FAIL b2b_first_ack no ack within 20 cycles");
        end else begin
            e = sb.pop_front();
            checks++;
            if ({fa, rd, er} !== {~e.is_d, e.rdata, e.err}) begin
                errors++; $display("FAIL b2b_first got f%b %h e%b want f1 %h e0", fa, rd, er, e.rdata);
            end
        end
        @(negedge clk);
        checks++;
        if (bus.mar_load !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap mar_load got %b want 0", bus.mar_load); end
        @(negedge clk);
        checks++;
        if (bus.mar_load !== 1'b1) begin errors++; $display("FAIL b2b_regrant mar_load got %b want 1", bus.mar_load); end
        wait_ack(20, seen, fa, da, rd, er, n, rs, ws);
        bus.f_req = 0;
        checks++;
        if (!seen) begin
            errors++; $display("FAIL b2b_second_ack no ack within 20 cycles");
        end else begin
            e = sb.pop_front();
            checks++;
            if ({fa, rd, er} !== {~e.is_d, e.rdata, e.err}) begin
                errors++; $display("FAIL b2b_second got f%b %h e%b want f1 %h e0", fa, rd, er, e.rdata);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_timeout(input int lat, input logic [DW-1:0] val, input logic exp_err);
        exp_t e; logic seen, fa, da, er, rs, ws; logic [DW-1:0] rd; int n;
        ready_lat = lat; mem_val = val; bus.f_addr = 32'h0000_0200; bus.f_req = 1;
        sb.push_back('{is_d: 1'b0, rdata: (exp_err ? '0 : val), err: exp_err});
        wait_ack(60, seen, fa, da, rd, er, n, rs, ws);
        bus.f_req = 0;
        checks++;
        if (!seen) begin
            errors++; $display("FAIL timeout_ack lat %0d no ack within 60 cycles", lat);
        end else begin
            e = sb.pop_front();
            checks++;
            if ({fa, da, rd, er} !== {~e.is_d, e.is_d, e.rdata, e.err}) begin
                errors++; $display("FAIL timeout_result lat %0d got f%b d%b %h e%b want f1 d0 %h e%b",
                                   lat, fa, da, rd, er, e.rdata, e.err);
            end
        end
        checks++;
        if (n != TMO) begin errors++; $display("FAIL timeout_cycles lat %0d got %0d want %0d", lat, n, TMO); end
        @(negedge clk);
        checks++;
        if ({bus.err, bus.f_ack} !== 2'b00) begin
            errors++; $display("FAIL timeout_pulse err/ack got %b%b want 00", bus.err, bus.f_ack);
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_write();
        test_contention();
        test_back_to_back();
        test_timeout(0, 32'h5555_AAAA, 1'b1);
        test_timeout(TMO, 32'h1357_2468, 1'b0);
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_left got %0d want 0", sb.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
